lfsr_period_ctrl: RTL

// Control stage driving the LFSR block's enable/seed inputs and consuming its data/done outputs.

---
 rtl/lfsr_period_ctrl_if.sv | 33 +++
 rtl/lfsr_period_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lfsr_period_ctrl_if.sv
// Bundle between the LFSR period controller and its requester/LFSR neighbours.
// The signal names are seen from the controller, so "slave" is the controller side.
interface lfsr_period_ctrl_if #(
   parameter int NUM_BITS = 32,
   parameter int DIV_BITS = 21,
   parameter int CNT_BITS = 32
);
   logic                i_Start;
   logic [NUM_BITS-1:0] i_Seed;
   logic [DIV_BITS-1:0] i_Div;
   logic [CNT_BITS-1:0] i_Max_Steps;
   logic                o_LFSR_Enable;
   logic                o_LFSR_Seed_DV;
   logic [NUM_BITS-1:0] o_LFSR_Seed_Data;
   logic                i_LFSR_Done;
   logic                o_Busy;
   logic                o_Done;
   logic [CNT_BITS-1:0] o_Period;
   logic                o_Timeout;
   logic                o_Lockup;

   modport slave (
      input  i_Start, i_Seed, i_Div, i_Max_Steps, i_LFSR_Done,
      output o_LFSR_Enable, o_LFSR_Seed_DV, o_LFSR_Seed_Data,
      output o_Busy, o_Done, o_Period, o_Timeout, o_Lockup
   );

   modport master (
      output i_Start, i_Seed, i_Div, i_Max_Steps, i_LFSR_Done,
      input  o_LFSR_Enable, o_LFSR_Seed_DV, o_LFSR_Seed_Data,
      input  o_Busy, o_Done, o_Period, o_Timeout, o_Lockup
   );
endinterface

// File: rtl/lfsr_period_ctrl.sv
// Seeds an external LFSR, paces it with enable strobes and measures the steps until it
// returns to the seed, with a step limit and all-ones (XNOR lockup) seed detection.
//
// state  | meaning
// IDLE   | waiting for i_Start; results of the last run held
// LOAD   | one cycle: Enable + Seed_DV load the captured seed into the LFSR
// RUN    | stepping at the divided rate until return to seed or limit
// REPORT | one-cycle o_Done pulse, then back to IDLE
module lfsr_period_ctrl #(
   parameter int NUM_BITS = 32,
   parameter int DIV_BITS = 21,
   parameter int CNT_BITS = 32
) (
   input logic               i_Clk,
   input logic               i_Rst_n,
   lfsr_period_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] seed_q, seed_d;
   logic [DIV_BITS-1:0] div_q, div_d;
   logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
   logic [CNT_BITS-1:0] max_q, max_d;
   logic [CNT_BITS-1:0] step_cnt_q, step_cnt_d;
   logic [CNT_BITS-1:0] period_q, period_d;
   logic                stepped_q, stepped_d;
   logic                timeout_q, timeout_d;
   logic                lockup_q, lockup_d;

   logic tick, at_limit, stop, run_enable;

   always_comb begin
      tick       = (div_cnt_q == div_q);
      at_limit   = (max_q != '0) && (step_cnt_q == max_q);
      // Done only counts after a real step: right after LOAD the LFSR already equals the seed.
      stop       = stepped_q && (bus.i_LFSR_Done || at_limit);
      run_enable = tick && !stop;
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q    <= IDLE;
         seed_q     <= '0;
         div_q      <= '0;
         div_cnt_q  <= '0;
         max_q      <= '0;
         step_cnt_q <= '0;
         period_q   <= '0;
         stepped_q  <= 1'b0;
         timeout_q  <= 1'b0;
         lockup_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_q     <= seed_d;
         div_q      <= div_d;
         div_cnt_q  <= div_cnt_d;
         max_q      <= max_d;
         step_cnt_q <= step_cnt_d;
         period_q   <= period_d;
         stepped_q  <= stepped_d;
         timeout_q  <= timeout_d;
         lockup_q   <= lockup_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      seed_d     = seed_q;
      div_d      = div_q;
      div_cnt_d  = div_cnt_q;
      max_d      = max_q;
      step_cnt_d = step_cnt_q;
      period_d   = period_q;
      stepped_d  = stepped_q;
      timeout_d  = timeout_q;
      lockup_d   = lockup_q;
      case (state_q)
         IDLE: begin
            if (bus.i_Start) begin
               seed_d    = bus.i_Seed;
               div_d     = bus.i_Div;
               max_d     = bus.i_Max_Steps;
               period_d  = '0;
               timeout_d = 1'b0;
               lockup_d  = 1'b0;
               if (&bus.i_Seed) begin
                  lockup_d = 1'b1;
                  state_d  = REPORT;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            div_cnt_d  = '0;
            step_cnt_d = '0;
            stepped_d  = 1'b0;
            state_d    = RUN;
         end
         RUN: begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_BITS'(1);
            stepped_d = run_enable;
            if (run_enable && !(&step_cnt_q)) step_cnt_d = step_cnt_q + CNT_BITS'(1);
            if (stop) begin
               if (bus.i_LFSR_Done) begin
                  period_d  = step_cnt_q;
                  timeout_d = 1'b0;
               end else begin
                  period_d  = max_q;
                  timeout_d = 1'b1;
               end
               state_d = REPORT;
            end
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.o_LFSR_Enable = 1'b0;
      bus.o_LFSR_Seed_DV = 1'b0;
      bus.o_Busy = 1'b0;
      bus.o_Done = 1'b0;
      case (state_q)
         LOAD: begin
            bus.o_LFSR_Enable  = 1'b1;
            bus.o_LFSR_Seed_DV = 1'b1;
            bus.o_Busy         = 1'b1;
         end
         RUN: begin
            bus.o_LFSR_Enable = run_enable;
            bus.o_Busy        = 1'b1;
         end
         REPORT:  bus.o_Done = 1'b1;
         default: ;
      endcase
   end

   assign bus.o_LFSR_Seed_Data = seed_q;
   assign bus.o_Period         = period_q;
   assign bus.o_Timeout        = timeout_q;
   assign bus.o_Lockup         = lockup_q;

endmodule
